// File: rtl/uart_apb_arbiter.sv
// APB master sharing one UART slave between NUM_REQ byte-transmit requesters,
// with priority draining of the UART receive register.
module uart_apb_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [31:0] CTRL_ADDR = 32'h0,
    parameter logic [31:0] TDR_ADDR  = 32'h4,
    parameter logic [31:0] RDR_ADDR  = 32'h8,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 err,
    output logic [31:0]          PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
    input  logic                 in_TX_Active,
    input  logic                 in_RXNE
);
    localparam int          PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR, S_TX_START, S_TX_END} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] next_gnt;
    logic [PW-1:0] scan;
    logic          found;
    logic [15:0]   tcnt;
    logic          rx_armed;
    logic          tmo;
    logic          unused_prdata;

    assign tmo           = (tcnt == TIMEOUT - 16'd1);
    assign unused_prdata = ^PRDATA[31:8];

    // Round-robin: first requester at or after ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        next_gnt = '0;
        scan     = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            scan = PW'((32'(ptr) + k) % NR);
            if (!found && req[scan]) begin
                found    = 1'b1;
                next_gnt = scan;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= S_INIT;
            ptr      <= '0;
            gnt      <= '0;
            tcnt     <= '0;
            rx_armed <= 1'b1;
            ack      <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            err      <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
        end else begin
            ack      <= '0;
            rx_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_INIT, S_RD, S_WR: begin
                    // RD/WR SETUP is issued from IDLE; only INIT starts here with the bus idle.
                    if (!PSEL) begin
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b1;
                        PADDR   <= CTRL_ADDR;
                        PWDATA  <= 32'h1;
                        tcnt    <= '0;
                    end else if (!PENABLE) begin
                        PENABLE <= 1'b1;
                    end else if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        PADDR   <= '0;
                        PWDATA  <= '0;
                        tcnt    <= '0;
                        err     <= PSLVERR;
                        case (state)
                            S_INIT: state <= PSLVERR ? S_INIT : S_IDLE;
                            S_RD: begin
                                if (!PSLVERR) begin
                                    rx_data  <= PRDATA[7:0];
                                    rx_valid <= 1'b1;
                                end
                                rx_armed <= 1'b0;
                                state    <= S_IDLE;
                            end
                            default: begin
                                ack[gnt] <= 1'b1;
                                ptr      <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
                                state    <= S_TX_START;
                            end
                        endcase
                    end else if (tmo) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        PADDR   <= '0;
                        PWDATA  <= '0;
                        tcnt    <= '0;
                        err     <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_IDLE: begin
                    if (in_RXNE && rx_armed) begin
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        PADDR   <= RDR_ADDR;
                        PWDATA  <= '0;
                        tcnt    <= '0;
                        state   <= S_RD;
                    end else if (found) begin
                        gnt     <= next_gnt;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b1;
                        PADDR   <= TDR_ADDR;
                        PWDATA  <= {24'h0, req_data[{next_gnt, 3'b000} +: 8]};
                        tcnt    <= '0;
                        state   <= S_WR;
                    end
                end
                S_TX_START: begin
                    if (in_TX_Active) begin
                        tcnt  <= '0;
                        state <= S_TX_END;
                    end else if (tmo) begin
                        tcnt  <= '0;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_TX_END: begin
                    if (!in_TX_Active) begin
                        tcnt  <= '0;
                        state <= S_IDLE;
                    end else if (tmo) begin
                        tcnt  <= '0;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Re-arm only once RXNE has been seen low, so one byte is read once.
            if (!in_RXNE) rx_armed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Bench for uart_apb_arbiter: APB slave + loopback UART model, scoreboarded
// APB transfers, acks and received bytes.
module tb_uart_apb_arbiter;
    localparam logic [15:0] TMO   = 16'd32;
    localparam int          FRAME = 10;
    localparam logic [31:0] CTRL  = 32'h0;
    localparam logic [31:0] TDR   = 32'h4;
    localparam logic [31:0] RDR   = 32'h8;

    typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} apb_t;
    typedef struct {int unsigned idx; logic [7:0] data; logic slverr; int unsigned exp_err;} vec_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  ack;
    logic [7:0]  rx_data;
    logic        rx_valid, err;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic        in_TX_Active = 1'b0;
    logic        in_RXNE;

    logic        ready_en = 1'b1;
    logic        slverr_en = 1'b0;
    logic        force_rxne = 1'b0;
    logic        loopback = 1'b1;
    logic        model_rxne = 1'b0;
    logic [7:0]  rx_reg = 8'h00;
    logic [7:0]  tx_byte = 8'h00;
    bit          tx_pend = 1'b0;
    int          tx_cnt = 0;
    bit          chk_ack_next = 1'b0;
    logic        slverr_prev = 1'b0;
    apb_t        mon_e;

    apb_t        apb_q[$];
    logic [1:0]  ack_q[$];
    logic [7:0]  rx_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_cnt = 0;
    vec_t        vecs[4];

    assign PREADY  = ready_en;
    assign PSLVERR = slverr_en;
    assign PRDATA  = {24'h0, rx_reg};
    assign in_RXNE = model_rxne | force_rxne;

    always #5 PCLK = ~PCLK;

    uart_apb_arbiter #(.NUM_REQ(2), .CTRL_ADDR(CTRL), .TDR_ADDR(TDR), .RDR_ADDR(RDR), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_data(req_data), .ack(ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .err(err), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .in_TX_Active(in_TX_Active), .in_RXNE(in_RXNE)
    );

    function automatic void check(string name, logic [95:0] got, logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    // Monitor and UART model, evaluated mid-cycle so DUT outputs are settled.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (err) err_cnt++;
            if (chk_ack_next) begin
                check("ack_latency", {94'h0, ack != 2'b00, err}, {94'h0, 1'b1, slverr_prev});
                chk_ack_next = 1'b0;
            end
            if (ack != 2'b00) begin
                if (ack_q.size() == 0) check("ack_unexpected", 96'(ack), 96'h0);
                else check("ack", 96'(ack), 96'(ack_q.pop_front()));
            end
            if (rx_valid) begin
                if (rx_q.size() == 0) check("rx_unexpected", 96'(rx_data), 96'h1ff);
                else check("rx_data", 96'(rx_data), 96'(rx_q.pop_front()));
            end
            if (PSEL && !PENABLE && PWRITE && PADDR == TDR)
                check("tx_idle_at_setup", 96'(tx_pend), 96'h0);
            if (PSEL && PENABLE && PREADY) begin
                if (apb_q.size() == 0) begin
                    check("apb_unexpected", {63'h0, PWRITE, PADDR}, 96'hffff_ffff_ffff);
                end else begin
                    mon_e = apb_q.pop_front();
                    check("apb_txn", {31'h0, PWRITE, PADDR, PWRITE ? PWDATA : 32'h0},
                          {31'h0, mon_e.wr, mon_e.addr, mon_e.wr ? mon_e.data : 32'h0});
                end
                if (PWRITE && PADDR == TDR) begin
                    chk_ack_next = 1'b1;
                    slverr_prev  = PSLVERR;
                    if (!PSLVERR) begin
                        tx_pend = 1'b1;
                        tx_byte = PWDATA[7:0];
                        tx_cnt  = 0;
                    end
                end
                if (!PWRITE && PADDR == RDR) model_rxne = 1'b0;
            end
            if (tx_pend) begin
                tx_cnt++;
                if (tx_cnt == 2) begin
                    in_TX_Active = 1'b1;
                end else if (tx_cnt == 2 + FRAME) begin
                    in_TX_Active = 1'b0;
                    tx_pend = 1'b0;
                    if (loopback) begin
                        rx_reg     = tx_byte;
                        model_rxne = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_ack(input int unsigned idx);
        logic seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (ack[idx]) begin
                seen     = 1'b1;
                req[idx] = 1'b0;
            end
        end
        check("ack_wait", 96'(seen), 96'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (apb_q.size() + ack_q.size() + rx_q.size() != 0 || tx_pend); i++)
            tick();
        check("drain_done", 96'(apb_q.size() + ack_q.size() + rx_q.size()), 96'h0);
        repeat (2 * int'(TMO)) tick();
    endtask

    task automatic push_tx(input int unsigned idx, input logic [7:0] d, input logic with_rx);
        apb_q.push_back('{1'b1, TDR, {24'h0, d}});
        ack_q.push_back(2'(1 << idx));
        if (with_rx) begin
            apb_q.push_back('{1'b0, RDR, 32'h0});
            rx_q.push_back(d);
        end
    endtask

    initial begin
        int e0;
        int acc;
        logic got_err;
        vecs[0] = '{0, 8'h55, 1'b0, 0};
        vecs[1] = '{1, 8'h3C, 1'b0, 0};
        vecs[2] = '{0, 8'h00, 1'b0, 0};
        vecs[3] = '{1, 8'hFF, 1'b1, 2};

        repeat (3) tick();
        check("reset_outputs", {17'h0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, ack, rx_data, rx_valid, err}, 96'h0);
        apb_q.push_back('{1'b1, CTRL, 32'h1});
        PRESET = 1'b0;
        drain();
        check("idle_outputs", {17'h0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, ack, rx_data, rx_valid, err}, 96'h0);

        foreach (vecs[v]) begin
            e0 = err_cnt;
            slverr_en = vecs[v].slverr;
            req_data[8*vecs[v].idx +: 8] = vecs[v].data;
            req[vecs[v].idx] = 1'b1;
            push_tx(vecs[v].idx, vecs[v].data, !vecs[v].slverr);
            wait_ack(vecs[v].idx);
            slverr_en = 1'b0;
            drain();
            check("vec_err_count", 96'(err_cnt - e0), 96'(vecs[v].exp_err));
        end

        // Two simultaneous requests, pointer at 0: requester 0 then 1.
        req_data = {8'h11, 8'hAA};
        req = 2'b11;
        push_tx(0, 8'hAA, 1'b1);
        push_tx(1, 8'h11, 1'b1);
        wait_ack(0);
        wait_ack(1);
        drain();

        // RXNE and request together: read first; held RXNE blocks a re-read.
        loopback = 1'b0;
        req_data[15:8] = 8'h77;
        force_rxne = 1'b1;
        req = 2'b10;
        apb_q.push_back('{1'b0, RDR, 32'h0});
        rx_q.push_back(8'h11);
        push_tx(1, 8'h77, 1'b0);
        wait_ack(1);
        drain();
        force_rxne = 1'b0;
        repeat (3) tick();
        apb_q.push_back('{1'b0, RDR, 32'h0});
        rx_q.push_back(8'h11);
        force_rxne = 1'b1;
        drain();
        force_rxne = 1'b0;
        loopback = 1'b1;

        // PREADY stuck low: timeout, no ack, same requester regranted.
        e0 = err_cnt;
        ready_en = 1'b0;
        req_data = {8'h6B, 8'h5A};
        req = 2'b11;
        acc = 0;
        got_err = 1'b0;
        for (int i = 0; i < 200 && !got_err; i++) begin
            tick();
            if (err) got_err = 1'b1;
            else if (PSEL && PENABLE) acc++;
        end
        check("timeout_err_seen", 96'(got_err), 96'h1);
        check("timeout_access_cycles", 96'(acc), 96'(TMO));
        check("timeout_bus_dropped", {94'h0, PSEL, PENABLE}, 96'h0);
        check("timeout_no_ack", 96'(ack), 96'h0);
        ready_en = 1'b1;
        push_tx(0, 8'h5A, 1'b1);
        push_tx(1, 8'h6B, 1'b1);
        wait_ack(0);
        wait_ack(1);
        drain();
        check("timeout_err_count", 96'(err_cnt - e0), 96'h1);

        // Reset in ACCESS aborts the write; INIT repeats, then the request is served.
        ready_en = 1'b0;
        req_data[7:0] = 8'h33;
        req = 2'b01;
        got_err = 1'b0;
        for (int i = 0; i < 50 && !got_err; i++) begin
            tick();
            if (PSEL && PENABLE) got_err = 1'b1;
        end
        check("reset_reach_access", 96'(got_err), 96'h1);
        PRESET = 1'b1;
        tick();
        check("reset_abort", {93'h0, PSEL, PENABLE, ack != 2'b00}, 96'h0);
        apb_q.push_back('{1'b1, CTRL, 32'h1});
        push_tx(0, 8'h33, 1'b1);
        ready_en = 1'b1;
        PRESET = 1'b0;
        wait_ack(0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
